// File: rtl/chest_pkg.sv
// Shared types and constants for the NB-IoT least-squares channel estimators.
package chest_pkg;

  localparam int unsigned NRS_PER_SLOT   = 4;
  localparam int unsigned SC_PER_PRB     = 12;
  localparam int unsigned NRS_SPACING    = 6;
  localparam int unsigned NRS_SYM_OFFSET = 3;

  localparam int unsigned ENTRY_W = 2;
  localparam int unsigned SYM_W   = 3;
  localparam int unsigned SC_W    = $clog2(SC_PER_PRB);
  localparam int unsigned CELL_W  = 9;
  localparam int unsigned VS_W    = 3;
  localparam int unsigned BITS_W  = 2 * NRS_PER_SLOT;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT,
    DONE
  } chest_state_e;

  typedef struct packed {
    logic               valid;
    logic [ENTRY_W-1:0] entry;
    logic               nrs_r;
    logic               nrs_i;
  } nrs_tag;

  // Frequency shift of the NRS pattern for a given cell.
  function automatic logic [VS_W-1:0] v_shift_of(input logic [CELL_W-1:0] cell_id);
    return VS_W'(cell_id % CELL_W'(NRS_SPACING));
  endfunction

endpackage

// File: rtl/nrs_re_addr_gen.sv
// Maps (v_shift, entry) to the NRS resource element (OFDM symbol, subcarrier).
module nrs_re_addr_gen
  import chest_pkg::*;
#(
  parameter int unsigned SYM_A = 5,
  parameter int unsigned SYM_B = 6
) (
  input  logic [VS_W-1:0]    v_shift_i,
  input  logic [ENTRY_W-1:0] entry_i,
  output logic [SYM_W-1:0]   sym_c_o,
  output logic [SC_W-1:0]    sc_c_o
);

  logic [VS_W-1:0] vs_c;

  // entry[1] selects the second NRS symbol, entry[0] the upper subcarrier of the pair
  always_comb begin
    vs_c = v_shift_i;
    if (entry_i[1]) begin
      vs_c = (v_shift_i < VS_W'(NRS_SYM_OFFSET)) ? v_shift_i + VS_W'(NRS_SYM_OFFSET)
                                                 : v_shift_i - VS_W'(NRS_SYM_OFFSET);
    end
    sym_c_o = entry_i[1] ? SYM_W'(SYM_B) : SYM_W'(SYM_A);
    sc_c_o  = SC_W'(vs_c) + (entry_i[0] ? SC_W'(NRS_SPACING) : SC_W'(0));
  end

endmodule

// File: rtl/chest_ls_ctrl.sv
// Port-0 LS channel-estimation slot sequencer: NRS grid reads, multiplier writes, estimate stream.
// Optional abort input enabled by defining CHEST_ABORT_EN.
module chest_ls_ctrl
  import chest_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned SYM_A  = 5,
  parameter int unsigned SYM_B  = 6
) (
  input  logic               clk,
  input  logic               rst,
`ifdef CHEST_ABORT_EN
  input  logic               abort,
`endif
  input  logic               start,
  input  logic [CELL_W-1:0]  cell_id,
  input  logic [BITS_W-1:0]  nrs_bits,
  output logic               grid_rd_en,
  output logic [SYM_W-1:0]   grid_sym,
  output logic [SC_W-1:0]    grid_sc,
  output logic               mult_en,
  output logic [ENTRY_W-1:0] mult_wr_addr,
  output logic               mult_nrs_r,
  output logic               mult_nrs_i,
  output logic [ENTRY_W-1:0] mult_rd_addr,
  output logic               est_valid,
  input  logic               est_ready,
  output logic [ENTRY_W-1:0] est_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(NRS_PER_SLOT - 1);

  chest_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] cnt_q, cnt_d;
  logic [ENTRY_W-1:0] est_idx_q, est_idx_d;
  logic [VS_W-1:0]    vs_q, vs_d;
  logic [BITS_W-1:0]  nrs_q, nrs_d;
  nrs_tag             tag_q [RD_LAT];
  nrs_tag             tag_d [RD_LAT];

  logic               grid_rd_en_q, grid_rd_en_d;
  logic [SYM_W-1:0]   grid_sym_q, grid_sym_d;
  logic [SC_W-1:0]    grid_sc_q, grid_sc_d;
  logic               est_valid_q, est_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               hs_c;
  logic               pipe_empty_c;
  logic [SYM_W-1:0]   sym_c;
  logic [SC_W-1:0]    sc_c;

  assign hs_c = est_valid_q & est_ready;

  nrs_re_addr_gen #(
    .SYM_A (SYM_A),
    .SYM_B (SYM_B)
  ) u_addr_gen (
    .v_shift_i (vs_d),
    .entry_i   (cnt_d),
    .sym_c_o   (sym_c),
    .sc_c_o    (sc_c)
  );

  // Tag pipeline tracks reads in flight so multiplier writes land RD_LAT cycles after each read
  always_comb begin
    for (int unsigned k = 0; k < RD_LAT; k++) tag_d[k] = '0;
    if (grid_rd_en_q) begin
      tag_d[0].valid = 1'b1;
      tag_d[0].entry = cnt_q;
      tag_d[0].nrs_r = nrs_q[{cnt_q, 1'b0}];
      tag_d[0].nrs_i = nrs_q[{cnt_q, 1'b1}];
    end
    for (int unsigned k = 1; k < RD_LAT; k++) tag_d[k] = tag_q[k-1];
`ifdef CHEST_ABORT_EN
    if (abort) begin
      for (int unsigned k = 0; k < RD_LAT; k++) tag_d[k] = '0;
    end
`endif
    pipe_empty_c = 1'b1;
    for (int unsigned k = 0; k < RD_LAT; k++) begin
      if (tag_d[k].valid) pipe_empty_c = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; DRAIN exits once the last multiplier write has been issued
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (cnt_q == LAST_ENTRY) state_d = DRAIN;
      DRAIN:   if (pipe_empty_c) state_d = OUT;
      OUT:     if (hs_c && est_idx_q == LAST_ENTRY) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef CHEST_ABORT_EN
    if (abort) state_d = IDLE;
`endif
  end

  // Outputs and datapath next values, all registered
  always_comb begin
    cnt_d        = '0;
    est_idx_d    = '0;
    vs_d         = vs_q;
    nrs_d        = nrs_q;
    grid_rd_en_d = 1'b0;
    grid_sym_d   = '0;
    grid_sc_d    = '0;
    est_valid_d  = 1'b0;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    if (state_q == IDLE && state_d == ISSUE) begin
      vs_d  = v_shift_of(cell_id);
      nrs_d = nrs_bits;
    end
    if (state_d == ISSUE) begin
      cnt_d        = (state_q == ISSUE) ? cnt_q + ENTRY_W'(1) : '0;
      grid_rd_en_d = 1'b1;
      grid_sym_d   = sym_c;
      grid_sc_d    = sc_c;
    end
    if (state_d == OUT) begin
      est_valid_d = 1'b1;
      est_idx_d   = hs_c ? est_idx_q + ENTRY_W'(1) : est_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      est_idx_q    <= '0;
      vs_q         <= '0;
      nrs_q        <= '0;
      grid_rd_en_q <= 1'b0;
      grid_sym_q   <= '0;
      grid_sc_q    <= '0;
      est_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int unsigned k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      cnt_q        <= cnt_d;
      est_idx_q    <= est_idx_d;
      vs_q         <= vs_d;
      nrs_q        <= nrs_d;
      grid_rd_en_q <= grid_rd_en_d;
      grid_sym_q   <= grid_sym_d;
      grid_sc_q    <= grid_sc_d;
      est_valid_q  <= est_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int unsigned k = 0; k < RD_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign grid_rd_en   = grid_rd_en_q;
  assign grid_sym     = grid_sym_q;
  assign grid_sc      = grid_sc_q;
  assign mult_en      = tag_q[RD_LAT-1].valid;
  assign mult_wr_addr = tag_q[RD_LAT-1].entry;
  assign mult_nrs_r   = tag_q[RD_LAT-1].nrs_r;
  assign mult_nrs_i   = tag_q[RD_LAT-1].nrs_i;
  assign mult_rd_addr = est_idx_q;
  assign est_valid    = est_valid_q;
  assign est_idx      = est_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_chest_ls_ctrl.sv
// Randomized bench for chest_ls_ctrl with RD_LAT=1 and RD_LAT=3 instances against a cycle-level slot model.
module tb_chest_ls_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] cell_id = '0;
  logic [7:0] nrs_bits = '0;
  logic       est_ready = 1'b0;
`ifdef CHEST_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       rd_en [2];
  logic [2:0] sym   [2];
  logic [3:0] sc    [2];
  logic       me    [2];
  logic [1:0] wa    [2];
  logic       nr    [2];
  logic       ni    [2];
  logic [1:0] ra    [2];
  logic       ev    [2];
  logic [1:0] idx   [2];
  logic       bsy   [2];
  logic       dn    [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    chest_ls_ctrl #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk          (clk),
      .rst          (rst),
`ifdef CHEST_ABORT_EN
      .abort        (abort),
`endif
      .start        (start),
      .cell_id      (cell_id),
      .nrs_bits     (nrs_bits),
      .grid_rd_en   (rd_en[g]),
      .grid_sym     (sym[g]),
      .grid_sc      (sc[g]),
      .mult_en      (me[g]),
      .mult_wr_addr (wa[g]),
      .mult_nrs_r   (nr[g]),
      .mult_nrs_i   (ni[g]),
      .mult_rd_addr (ra[g]),
      .est_valid    (ev[g]),
      .est_ready    (est_ready),
      .est_idx      (idx[g]),
      .busy         (bsy[g]),
      .done         (dn[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_inst(input int i, input string pre,
                            input logic erd, input logic [2:0] esym, input logic [3:0] esc,
                            input logic eme, input logic [1:0] ewa, input logic enr, input logic eni,
                            input logic eev, input logic [1:0] eidx, input logic ebusy, input logic edone);
    check_eq({pre, " grid_rd_en"},   32'(rd_en[i]), 32'(erd));
    check_eq({pre, " grid_sym"},     32'(sym[i]),   32'(esym));
    check_eq({pre, " grid_sc"},      32'(sc[i]),    32'(esc));
    check_eq({pre, " mult_en"},      32'(me[i]),    32'(eme));
    check_eq({pre, " mult_wr_addr"}, 32'(wa[i]),    32'(ewa));
    check_eq({pre, " mult_nrs_r"},   32'(nr[i]),    32'(enr));
    check_eq({pre, " mult_nrs_i"},   32'(ni[i]),    32'(eni));
    check_eq({pre, " mult_rd_addr"}, 32'(ra[i]),    32'(eidx));
    check_eq({pre, " est_valid"},    32'(ev[i]),    32'(eev));
    check_eq({pre, " est_idx"},      32'(idx[i]),   32'(eidx));
    check_eq({pre, " busy"},         32'(bsy[i]),   32'(ebusy));
    check_eq({pre, " done"},         32'(dn[i]),    32'(edone));
  endtask

  // One slot, start pulsed in cycle 0. mode: 0 ready tied high, 1 fixed toggle pattern, 2 random.
  // abort_c / rst_c: cycle in which abort / reset is applied (-1 = never).
  task automatic run_seq(input logic [8:0] cid, input logic [7:0] bits, input int mode,
                         input bit extra, input int abort_c, input int rst_c);
    int acc [2];
    int acc4 [2];
    int zc, vs, c, last;
    bit fin;
    logic rdy;
    acc  = '{0, 0};
    acc4 = '{-1, -1};
    zc   = (rst_c >= 0) ? rst_c : ((abort_c >= 0) ? abort_c + 1 : 1000);
    vs   = int'(cid) % 6;
    c    = 0;
    fin  = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      start    = (c == 0) || (extra && (c == 2 || c == 10));
      cell_id  = (c == 0) ? cid : 9'($urandom_range(0, 503));
      nrs_bits = (c == 0) ? bits : 8'($urandom);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[c % 5];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      est_ready = rdy;
`ifdef CHEST_ABORT_EN
      abort = (c == abort_c);
`endif
      if (c == rst_c) rst = 1'b0;
      if (c == rst_c + 1) rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int L, e, w;
        logic erd, eme, eev, ebusy, edone, enr, eni;
        logic [2:0] esym;
        logic [3:0] esc;
        logic [1:0] ewa, eidx;
        L     = (i == 0) ? 1 : 3;
        e     = c - 1;
        erd   = (c >= 1 && c <= 4);
        esym  = erd ? ((e < 2) ? 3'd5 : 3'd6) : 3'd0;
        esc   = erd ? 4'(6 * (e % 2) + ((e < 2) ? vs : (vs + 3) % 6)) : 4'd0;
        w     = c - 1 - L;
        eme   = (c >= 1 + L && c <= 4 + L);
        ewa   = eme ? 2'(w) : 2'd0;
        enr   = eme ? bits[2 * w] : 1'b0;
        eni   = eme ? bits[2 * w + 1] : 1'b0;
        eev   = (c >= 5 + L) && (acc[i] < 4);
        eidx  = eev ? 2'(acc[i]) : 2'd0;
        edone = (acc4[i] >= 0) && (c == acc4[i] + 1);
        ebusy = (c >= 1) && ((acc4[i] < 0) || (c <= acc4[i] + 1));
        if (c >= zc) begin
          {erd, esym, esc, eme, ewa, enr, eni, eev, eidx, ebusy, edone} = '0;
        end
        check_inst(i, $sformatf("L%0d cell%0d c%0d", L, cid, c),
                   erd, esym, esc, eme, ewa, enr, eni, eev, eidx, ebusy, edone);
        if (eev && rdy) begin
          acc[i]++;
          if (acc[i] == 4) acc4[i] = c;
        end
      end
      last = (acc4[0] > acc4[1]) ? acc4[0] : acc4[1];
      if (zc < 1000 && c >= zc + 8) fin = 1'b1;
      else if (acc4[0] >= 0 && acc4[1] >= 0 && c >= last + 4) fin = 1'b1;
      else if (c >= 80) begin
        check_eq($sformatf("timeout cell%0d handshakes", cid), 32'(acc[0] + acc[1]), 32'd8);
        fin = 1'b1;
      end
      c++;
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    est_ready = 1'b0;
`ifdef CHEST_ABORT_EN
    abort     = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_inst(i, $sformatf("reset L%0d", (i == 0) ? 1 : 3),
                 1'b0, 3'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_seq(9'd0,   8'($urandom), 0, 1'b0, -1, -1);
    run_seq(9'd503, 8'b10_01_11_00, 0, 1'b0, -1, -1);
    run_seq(9'd7,   8'($urandom), 0, 1'b0, -1, -1);
    run_seq(9'($urandom_range(0, 503)), 8'($urandom), 1, 1'b0, -1, -1);
    run_seq(9'($urandom_range(0, 503)), 8'($urandom), 0, 1'b1, -1, -1);
    for (int k = 0; k < 6; k++) begin
      run_seq(9'($urandom_range(0, 503)), 8'($urandom), 2, 1'b0, -1, -1);
    end
    run_seq(9'($urandom_range(0, 503)), 8'($urandom), 0, 1'b0, -1, 5);
    run_seq(9'($urandom_range(0, 503)), 8'($urandom), 2, 1'b0, -1, -1);
`ifdef CHEST_ABORT_EN
    run_seq(9'($urandom_range(0, 503)), 8'($urandom), 0, 1'b0, 2, -1);
    run_seq(9'($urandom_range(0, 503)), 8'($urandom), 0, 1'b0, -1, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
